if_fetch_unit: RTL

- Instruction-fetch initiator for the RV32I pipeline; drives the `imem` read/ready interface (Addr/read/ready/ins) from a PC register.
- Buffers fetched instructions with their PCs in a small FIFO.
- Presents them to the IF/ID boundary with a valid/ready handshake.
- Handles branch/jump redirects from EX, including discarding an in-flight response.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath widths, reset/NOP constants and fetch-side types.
package riscv_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ILEN          = 32;
  localparam int unsigned FETCH_ENTRY_W = XLEN + ILEN;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte offset so redirect targets land on a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head entry is held in a register that keeps
// its last value while the FIFO is empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_ENTRY_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    remain;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;

  // Next head: an older surviving entry wins, else a push into an emptied FIFO.
  always_comb begin
    do_pop      = pop && !empty;
    do_push     = push && (!full || do_pop);
    remain      = count - CW'(do_pop);
    rd_ptr_next = rd_ptr + AW'(do_pop);
    count_next  = remain + CW'(do_push);
    head_next   = head_data;
    if (flush) begin
      count_next = '0;
    end else if (remain != '0) begin
      head_next = mem[rd_ptr_next];
    end else if (do_push) begin
      head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      head_data <= '0;
    end else begin
      head_data <= head_next;
      count     <= count_next;
      full      <= (count_next == CW'(DEPTH));
      empty     <= (count_next == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr_next;
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch initiator: issues imem reads from the PC, buffers {pc, instr}
// pairs and hands them to decode; EX redirects flush the buffer and retarget the PC.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_read,
  input  logic            imem_ready,
  input  logic [ILEN-1:0] imem_ins,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            id_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pending_pc;
  logic [XLEN-1:0] target;
  logic            xfer;
  logic            push;
  logic            pop;
  logic            space;
  logic [CW-1:0]   count_next;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign imem_addr = pc;
  assign if_valid  = !fifo_empty;
  assign if_pc     = head_entry.pc;
  assign if_instr  = head_entry.instr;

  // Handshake decode and next-cycle occupancy used to decide whether to keep reading.
  always_comb begin
    target     = align_pc(redirect_pc);
    xfer       = imem_read && imem_ready;
    pop        = if_valid && id_ready;
    push       = (state == FETCH) && xfer && !redirect_valid && (!fifo_full || pop);
    count_next = redirect_valid ? '0 : fifo_count + CW'(push) - CW'(pop);
    space      = (count_next < CW'(FIFO_DEPTH));
    push_entry = '{pc: pc, instr: imem_ins};
  end

  // A read, once raised, stays up with a stable address until imem_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      pending_pc <= '0;
      imem_read  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid && imem_read && !imem_ready) begin
            state      <= DRAIN;
            pending_pc <= target;
          end else if (redirect_valid) begin
            pc        <= target;
            imem_read <= 1'b1;
          end else begin
            if (xfer) pc <= pc + PC_STEP;
            imem_read <= (imem_read && !imem_ready) || space;
          end
        end
        DRAIN: begin
          if (imem_ready) begin
            state <= FETCH;
            pc    <= redirect_valid ? target : pending_pc;
          end else if (redirect_valid) begin
            pending_pc <= target;
          end
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (head_entry)
  );

endmodule
